// File: rtl/gpu_cmd_queue.sv
// First-word-fall-through command queue between the host command decoder and the draw engine.
// Adds valid/ready handshakes, flush, occupancy/almost-full, a sticky overflow flag and high-water telemetry.
module gpu_cmd_queue #(
    parameter int  DATA_W       = 79,
    parameter int  DEPTH        = 8,
    parameter int  AFULL_THRESH = DEPTH - 2,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush_i,
    input  logic              push_valid_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              push_ready_o,
    output logic              pop_valid_o,
    output logic [DATA_W-1:0] pop_data_o,
    input  logic              pop_ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  hwm_o,
    input  logic              stat_clr_i
);

    localparam int                 PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   AFULL_C = CNT_W'(AFULL_THRESH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic [CNT_W-1:0]  hwm_r;

    logic              push_fire_s;
    logic              pop_fire_s;
    logic [PTR_W-1:0]  wr_ptr_next_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              overflow_next_s;
    logic [CNT_W-1:0]  hwm_next_s;

    // Status flags are pure decodes of the registered count, so a pop never frees a slot in the same cycle.
    assign push_ready_o  = (count_r < DEPTH_C);
    assign pop_valid_o   = (count_r != {CNT_W{1'b0}});
    assign almost_full_o = (count_r >= AFULL_C);
    assign count_o       = count_r;
    assign overflow_o    = overflow_r;
    assign hwm_o         = hwm_r;
    assign pop_data_o    = pop_valid_o ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

    assign push_fire_s = push_valid_i & push_ready_o;
    assign pop_fire_s  = pop_valid_o & pop_ready_i;

    // Next pointer/count state; flush wins over any handshake in the same cycle.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (flush_i) begin
            wr_ptr_next_s = {PTR_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_next_s = wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_fire_s) begin
                rd_ptr_next_s = rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_fire_s, pop_fire_s})
                2'b10:   count_next_s = count_r + 1'b1;
                2'b01:   count_next_s = count_r - 1'b1;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Telemetry next state; a clear outranks a same-cycle overflow and reloads the mark from the new count.
    always_comb begin
        overflow_next_s = overflow_r;
        hwm_next_s      = hwm_r;
        if (stat_clr_i) begin
            overflow_next_s = 1'b0;
            hwm_next_s      = count_next_s;
        end else begin
            if (push_valid_i && !push_ready_o && !flush_i) begin
                overflow_next_s = 1'b1;
            end else begin
                overflow_next_s = overflow_r;
            end
            if (count_next_s > hwm_r) begin
                hwm_next_s = count_next_s;
            end else begin
                hwm_next_s = hwm_r;
            end
        end
    end

    // Control and telemetry registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            hwm_r      <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            overflow_r <= overflow_next_s;
            hwm_r      <= hwm_next_s;
        end
    end

    // Storage array; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_fire_s && !flush_i) begin
            mem_r[wr_ptr_r] <= push_data_i;
        end
    end

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Self-checking bench for gpu_cmd_queue: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_gpu_cmd_queue;

    localparam int DW    = 79;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          flush_i;
    logic          push_valid_i;
    logic [DW-1:0] push_data_i;
    logic          push_ready_o;
    logic          pop_valid_o;
    logic [DW-1:0] pop_data_o;
    logic          pop_ready_i;
    logic [CW-1:0] count_o;
    logic          almost_full_o;
    logic          overflow_o;
    logic [CW-1:0] hwm_o;
    logic          stat_clr_i;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    bit            ovf_m;
    int            hwm_m;

    typedef struct {
        bit            pv;
        logic [DW-1:0] d;
        bit            pr;
        int            exp_cnt;
        logic [DW-1:0] exp_head;
        bit            exp_af;
        bit            exp_rdy;
    } vec_t;

    vec_t tbl[16];

    gpu_cmd_queue #(.DATA_W(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_data_i  (push_data_i),
        .push_ready_o (push_ready_o),
        .pop_valid_o  (pop_valid_o),
        .pop_data_o   (pop_data_o),
        .pop_ready_i  (pop_ready_i),
        .count_o      (count_o),
        .almost_full_o(almost_full_o),
        .overflow_o   (overflow_o),
        .hwm_o        (hwm_o),
        .stat_clr_i   (stat_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("count", 128'(count_o), 128'(q.size()));
        chk("push_ready", 128'(push_ready_o), 128'(q.size() < DEPTH));
        chk("pop_valid", 128'(pop_valid_o), 128'(q.size() != 0));
        chk("pop_data", 128'(pop_data_o), (q.size() != 0) ? 128'(q[0]) : 128'd0);
        chk("almost_full", 128'(almost_full_o), 128'(q.size() >= AF));
        chk("overflow", 128'(overflow_o), 128'(ovf_m));
        chk("hwm", 128'(hwm_o), 128'(hwm_m));
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0;
        hwm_m = 0;
    endtask

    // One clock: drive inputs just after a falling edge, check state, step model on the rising edge.
    task automatic cycle(input bit pv, input logic [DW-1:0] d, input bit pr, input bit fl, input bit clr);
        bit full;
        bit pf;
        bit popf;
        push_valid_i = pv;
        push_data_i  = d;
        pop_ready_i  = pr;
        flush_i      = fl;
        stat_clr_i   = clr;
        #1;
        check_model();
        full = (q.size() == DEPTH);
        pf   = pv && !full;
        popf = pr && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (popf) void'(q.pop_front());
            if (pf) q.push_back(d);
        end
        if (clr) begin
            ovf_m = 1'b0;
            hwm_m = q.size();
        end else begin
            if (pv && full && !fl) ovf_m = 1'b1;
            if (q.size() > hwm_m) hwm_m = q.size();
        end
        @(negedge clk);
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        flush_i      = 1'b0;
        stat_clr_i   = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            k;

        // Test 1 vectors: eight pushes then eight pops, with the outputs expected after each edge.
        for (int i = 0; i < 8; i++) begin
            tbl[i].pv       = 1'b1;
            tbl[i].d        = DW'(i + 1);
            tbl[i].pr       = 1'b0;
            tbl[i].exp_cnt  = i + 1;
            tbl[i].exp_head = DW'(1);
            tbl[i].exp_af   = (i + 1) >= 6;
            tbl[i].exp_rdy  = (i + 1) < 8;
        end
        for (int i = 0; i < 8; i++) begin
            tbl[8+i].pv       = 1'b0;
            tbl[8+i].d        = '0;
            tbl[8+i].pr       = 1'b1;
            tbl[8+i].exp_cnt  = 7 - i;
            tbl[8+i].exp_head = (i < 7) ? DW'(i + 2) : '0;
            tbl[8+i].exp_af   = (7 - i) >= 6;
            tbl[8+i].exp_rdy  = 1'b1;
        end

        nrst         = 1'b0;
        flush_i      = 1'b0;
        push_valid_i = 1'b0;
        push_data_i  = '0;
        pop_ready_i  = 1'b0;
        stat_clr_i   = 1'b0;
        model_reset();
        #3;
        chk("rst_count", 128'(count_o), 128'd0);
        chk("rst_push_ready", 128'(push_ready_o), 128'd1);
        chk("rst_pop_valid", 128'(pop_valid_o), 128'd0);
        chk("rst_pop_data", 128'(pop_data_o), 128'd0);
        chk("rst_almost_full", 128'(almost_full_o), 128'd0);
        chk("rst_overflow", 128'(overflow_o), 128'd0);
        chk("rst_hwm", 128'(hwm_o), 128'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Test 1: table-driven fill and drain.
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].pv, tbl[i].d, tbl[i].pr, 1'b0, 1'b0);
            chk($sformatf("t1_count[%0d]", i), 128'(count_o), 128'(tbl[i].exp_cnt));
            chk($sformatf("t1_head[%0d]", i), 128'(pop_data_o), 128'(tbl[i].exp_head));
            chk($sformatf("t1_afull[%0d]", i), 128'(almost_full_o), 128'(tbl[i].exp_af));
            chk($sformatf("t1_ready[%0d]", i), 128'(push_ready_o), 128'(tbl[i].exp_rdy));
            if (i == 7) chk("t1_hwm_full", 128'(hwm_o), 128'd8);
        end
        chk("t1_empty_valid", 128'(pop_valid_o), 128'd0);

        // Test 2: order preserved across pointer wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd = pop_data_o;
            chk($sformatf("t2_order[%0d]", i), 128'(rd), 128'(8'hA0 + i));
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("t2_count_zero", 128'(count_o), 128'd0);

        // Test 3: sustained simultaneous push and pop at count 3.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h300 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t3_order[%0d]", i), 128'(pop_data_o), 128'(16'h300 + i));
            cycle(1'b1, DW'(16'h303 + i), 1'b1, 1'b0, 1'b0);
        end
        chk("t3_count_held", 128'(count_o), 128'd3);

        // Test 4: full with simultaneous pop; push rejected, overflow set, then cleared.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h400 + i), 1'b0, 1'b0, 1'b0);
        chk("t4_full_ready", 128'(push_ready_o), 128'd0);
        cycle(1'b1, DW'(16'h4FF), 1'b1, 1'b0, 1'b0);
        chk("t4_count", 128'(count_o), 128'd7);
        chk("t4_overflow", 128'(overflow_o), 128'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t4_clr_overflow", 128'(overflow_o), 128'd0);
        chk("t4_clr_hwm", 128'(hwm_o), 128'd7);

        // Test 5: flush with a same-cycle push.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("t5_pre_count", 128'(count_o), 128'd5);
        cycle(1'b1, DW'(16'h5AA), 1'b0, 1'b1, 1'b0);
        chk("t5_count", 128'(count_o), 128'd0);
        chk("t5_pop_valid", 128'(pop_valid_o), 128'd0);
        chk("t5_overflow", 128'(overflow_o), 128'd0);
        chk("t5_hwm", 128'(hwm_o), 128'd5);

        // Flush while full with a push pending must not set overflow.
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(16'h500 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'(16'h5BB), 1'b0, 1'b1, 1'b0);
        chk("t5_full_flush_ovf", 128'(overflow_o), 128'd0);

        // Test 6: asynchronous reset between edges at count 4.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'h600 + i), 1'b0, 1'b0, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        chk("t6_count", 128'(count_o), 128'd0);
        chk("t6_push_ready", 128'(push_ready_o), 128'd1);
        chk("t6_pop_valid", 128'(pop_valid_o), 128'd0);
        chk("t6_pop_data", 128'(pop_data_o), 128'd0);
        chk("t6_almost_full", 128'(almost_full_o), 128'd0);
        chk("t6_hwm", 128'(hwm_o), 128'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        cycle(1'b1, DW'(16'h6AB), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'(16'h6CD), 1'b0, 1'b0, 1'b0);
        chk("t6_first_word", 128'(pop_data_o), 128'(16'h6AB));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom, $urandom, $urandom};
            k  = (i / 500) % 3;
            cycle(($urandom_range(99) < ((k == 1) ? 85 : 60)),
                  rd,
                  ($urandom_range(99) < ((k == 2) ? 85 : 55)),
                  ($urandom_range(99) < 3),
                  ($urandom_range(99) < 3));
        end
        #1;
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_cmd_queue.md
Name: gpu_cmd_queue

Overview:
- Parametrised, first-word-fall-through command queue between the host command decoder and the GPU draw engine.
- Successor to the fixed 79-bit × 8 instruction FIFO. Generalised in data width and depth.
- Adds:
  - valid/ready handshakes on both sides
  - true simultaneous push+pop
  - synchronous flush
  - occupancy count and almost-full threshold
  - sticky overflow flag
  - high-water-mark telemetry

Parameters:
DATA_W, 79, width of one packed command word (opcode, coordinates, radius, colour, quadrant).
DEPTH, 8, number of entries; power of two, 2..256.
AFULL_THRESH, DEPTH-2, almost_full_o asserts when count_o >= AFULL_THRESH; legal range 1..DEPTH.
CNT_W, $clog2(DEPTH)+1, width of occupancy/high-water outputs (derived, not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
nrst  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous discard of all queued entries
push_valid_i  in  1  producer offers push_data_i this cycle
push_data_i  in  DATA_W  command word to enqueue
push_ready_o  out  1  queue can accept (count_o < DEPTH)
pop_valid_o  out  1  head entry available (count_o != 0)
pop_data_o  out  DATA_W  head entry; all-zero when pop_valid_o=0
pop_ready_i  in  1  consumer takes head this cycle
count_o  out  CNT_W  current occupancy, 0..DEPTH
almost_full_o  out  1  count_o >= AFULL_THRESH
overflow_o  out  1  sticky: push attempted while full
hwm_o  out  CNT_W  maximum count_o observed since reset/clear
stat_clr_i  in  1  synchronous clear of overflow_o and hwm_o

Behaviour:
- Reset (nrst=0, asynchronous):
  - read/write pointers and count go to 0; overflow_o=0, hwm_o=0.
  - Outputs: push_ready_o=1, pop_valid_o=0, pop_data_o=0, almost_full_o=0.
  - Storage array is not reset.
  - Reset asserted mid-transfer discards all contents; no partial-state recovery.
- Handshakes:
  - push_fire = push_valid_i & push_ready_o.
  - pop_fire = pop_valid_o & pop_ready_i.
  - Only fire events change state. Producer must hold data stable only within the firing cycle.
- Write: on push_fire, mem[wr_ptr] <= push_data_i and wr_ptr <= wr_ptr+1, modulo DEPTH with natural wrap.
- Read: pop_data_o = mem[rd_ptr] combinationally (FWFT). On pop_fire, rd_ptr <= rd_ptr+1, modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged, both pointers advance
  - neither: hold
- Latency:
  - A word pushed at edge N is visible on pop_data_o with pop_valid_o=1 after edge N.
  - No same-cycle empty bypass.
- Full (count=DEPTH): push_ready_o=0. A simultaneous pop does not raise push_ready_o in the same cycle; no full bypass.
- Empty (count=0): pop_valid_o=0 and pop_ready_i is ignored. Empty is not an error.
- Overflow:
  - push_valid_i=1 while push_ready_o=0 sets overflow_o on the next edge.
  - The word is dropped; queue state is unchanged.
- Flush:
  - flush_i=1 at an edge sets pointers and count to 0, and has priority over push/pop that cycle.
  - Push/pop in a flush cycle are discarded and do not set overflow_o.
  - overflow_o and hwm_o are not affected by flush.
- High-water mark: hwm_o <= max(hwm_o, next_count) each edge.
- stat_clr_i:
  - Clears overflow_o and loads hwm_o with next_count.
  - Takes priority over a same-cycle overflow set.
- Width rules:
  - Pointers are $clog2(DEPTH) bits; count is CNT_W bits.
  - Comparisons are unsigned.
  - DEPTH=2^k requires no explicit rollover logic.

Test Plan:
1. DEPTH=8, DATA_W=79: push 0x01..0x08 back-to-back.
   - After 8 pushes: push_ready_o=0, count_o=8, almost_full_o=1 from count 6, hwm_o=8.
   - Popping 8 times yields 0x01..0x08 in order; then pop_valid_o=0, pop_data_o=0.
2. Wrap: push 5, pop 5, push 8 (0xA0..0xA7), pop all.
   - Order is preserved across the pointer wrap; count_o returns to 0.
3. Simultaneous: with count=3, hold push_valid_i=pop_ready_i=1 for 20 cycles.
   - count_o stays 3; output sequence is strictly in push order.
4. Full with pop: with count=8, push_valid_i=1 and pop_ready_i=1.
   - Pop fires, push is rejected, count_o=7, overflow_o=1.
   - A stat_clr_i pulse clears overflow_o and sets hwm_o=7.
5. Flush: count=5, flush_i=1 together with push_valid_i=1.
   - Next cycle: count_o=0, pop_valid_o=0, overflow_o=0, hwm_o=5.
6. Async reset asserted mid-burst (count=4, between edges).
   - Outputs go to reset values immediately.
   - After release, the first pushed word is the first popped.
